// File: rtl/noc_ni_tx_pkg.sv
// Shared definitions for the noc_ni_tx network-interface packetizer.
// Holds the flit width, the address width, the flit-type codes, the bit positions of the
// header fields, the FSM state type and the length clamp helper.
package noc_ni_tx_pkg;

    localparam int unsigned DATA_WIDTH = 32;  // only 32 is supported
    localparam int unsigned AXIS       = 4;   // node address width
    localparam int unsigned LEN_W      = 12;
    localparam int unsigned PAY_W      = 28;
    localparam int unsigned SEQ_W      = 8;
    localparam int unsigned CNT_W      = 16;

    // One-hot flit type codes in [31:29]
    localparam logic [2:0] FLIT_HEAD = 3'b001;
    localparam logic [2:0] FLIT_BODY = 3'b010;
    localparam logic [2:0] FLIT_TAIL = 3'b100;

    // Field positions inside a flit
    localparam int unsigned TYPE_MSB = 31;
    localparam int unsigned TYPE_LSB = 29;
    localparam int unsigned LEN_MSB  = 28;
    localparam int unsigned LEN_LSB  = 17;
    localparam int unsigned DST_MSB  = 16;
    localparam int unsigned DST_LSB  = 13;
    localparam int unsigned SRC_MSB  = 12;
    localparam int unsigned SRC_LSB  = 9;
    localparam int unsigned SEQ_MSB  = 8;
    localparam int unsigned SEQ_LSB  = 1;
    localparam int unsigned PAY_MSB  = 28;
    localparam int unsigned PAY_LSB  = 1;

    typedef enum logic [2:0] {
        StIdle,
        StHead,
        StBody,
        StTail,
        StGap
    } ni_state_e;

    // A packet always carries at least a header and a tail.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len < 12'd2) ? 12'd2 : len;
    endfunction

endpackage

// File: rtl/noc_ni_tx_if.sv
// Signal bundle between the packet source / router link and noc_ni_tx.
//   pkt_valid/pkt_ready/pkt_dst/pkt_len : packet request handshake
//   pay_valid/pay_ready/pay_data        : payload word stream
//   TX/RTS/DCTS                         : flit link into the router Local port
//   busy/pkt_cnt                        : status
// modport slave is the packetizer, modport master is the host/router side.
interface noc_ni_tx_if;
    import noc_ni_tx_pkg::*;

    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [AXIS-1:0]       pkt_dst;
    logic [LEN_W-1:0]      pkt_len;
    logic                  pay_valid;
    logic                  pay_ready;
    logic [PAY_W-1:0]      pay_data;
    logic [DATA_WIDTH-1:0] TX;
    logic                  RTS;
    logic                  DCTS;
    logic                  busy;
    logic [CNT_W-1:0]      pkt_cnt;

    modport master (
        output pkt_valid, pkt_dst, pkt_len, pay_valid, pay_data, DCTS,
        input  pkt_ready, pay_ready, TX, RTS, busy, pkt_cnt
    );

    modport slave (
        input  pkt_valid, pkt_dst, pkt_len, pay_valid, pay_data, DCTS,
        output pkt_ready, pay_ready, TX, RTS, busy, pkt_cnt
    );

endinterface

// File: rtl/noc_ni_tx_flit_builder.sv
// Combinational assembly of one 32-bit flit from its type, header fields or payload word.
//   flit_type_i : one-hot flit type; FLIT_HEAD selects the header layout
//   len_i, dst_i, src_i, seq_i : header fields
//   pay_i       : payload word for body/tail flits
//   flit_o      : assembled flit, bit 0 is parity
// Build option: NI_PARITY_EN defined gives even parity in bit 0, otherwise bit 0 is 0.
module noc_ni_tx_flit_builder
    import noc_ni_tx_pkg::*;
(
    input  logic [2:0]            flit_type_i,
    input  logic [LEN_W-1:0]      len_i,
    input  logic [AXIS-1:0]       dst_i,
    input  logic [AXIS-1:0]       src_i,
    input  logic [SEQ_W-1:0]      seq_i,
    input  logic [PAY_W-1:0]      pay_i,
    output logic [DATA_WIDTH-1:0] flit_o
);

    logic [DATA_WIDTH-1:1] fields;

    always_comb begin
        fields = '0;
        fields[TYPE_MSB:TYPE_LSB] = flit_type_i;
        if (flit_type_i == FLIT_HEAD) begin
            fields[LEN_MSB:LEN_LSB] = len_i;
            fields[DST_MSB:DST_LSB] = dst_i;
            fields[SRC_MSB:SRC_LSB] = src_i;
            fields[SEQ_MSB:SEQ_LSB] = seq_i;
        end else begin
            fields[PAY_MSB:PAY_LSB] = pay_i;
        end
    end

`ifdef NI_PARITY_EN
    assign flit_o = {fields, ^fields};
`else
    assign flit_o = {fields, 1'b0};
`endif

endmodule

// File: rtl/noc_ni_tx.sv
// Network-interface packetizer: turns a (dst, len) request plus a payload word stream into
// header, body and tail flits on the router Local-port RTS/CTS link.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : noc_ni_tx_if.slave (request, payload, TX/RTS/DCTS link, busy, pkt_cnt)
// Every issued flit is followed by one GAP cycle so DCTS is re-sampled after each write.
// Build option: NI_PARITY_EN (see noc_ni_tx_flit_builder).
module noc_ni_tx
    import noc_ni_tx_pkg::*;
#(
    parameter logic [AXIS-1:0] SRC_ADDR = 4'b0000
) (
    input  logic         clk,
    input  logic         rst,
    noc_ni_tx_if.slave   bus
);

    ni_state_e             state_q, ret_q;
    logic [AXIS-1:0]       dst_q;
    logic [LEN_W-1:0]      len_q, rem_q;
    logic [SEQ_W-1:0]      seq_q;
    logic [CNT_W-1:0]      pkt_cnt_q;
    logic [DATA_WIDTH-1:0] tx_q;
    logic                  rts_q;

    logic [LEN_W-1:0]      req_len;
    logic [2:0]            flit_type;
    logic [DATA_WIDTH-1:0] flit;
    logic                  take_word;

    assign req_len = clamp_len(bus.pkt_len);

    // A payload word is captured only in BODY/TAIL when the router can accept the flit.
    assign take_word = ((state_q == StBody) || (state_q == StTail)) && bus.DCTS && bus.pay_valid;

    always_comb begin
        flit_type = FLIT_TAIL;
        if (state_q == StHead) begin
            flit_type = FLIT_HEAD;
        end else if (state_q == StBody) begin
            flit_type = FLIT_BODY;
        end
    end

    noc_ni_tx_flit_builder u_flit_builder (
        .flit_type_i (flit_type),
        .len_i       (len_q),
        .dst_i       (dst_q),
        .src_i       (SRC_ADDR),
        .seq_i       (seq_q),
        .pay_i       (bus.pay_data),
        .flit_o      (flit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            ret_q     <= StIdle;
            dst_q     <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            seq_q     <= '0;
            pkt_cnt_q <= '0;
            tx_q      <= '0;
            rts_q     <= 1'b0;
        end else begin
            rts_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.pkt_valid) begin
                        dst_q   <= bus.pkt_dst;
                        len_q   <= req_len;
                        rem_q   <= req_len - 12'd2;
                        state_q <= StHead;
                    end
                end
                StHead: begin
                    if (bus.DCTS) begin
                        tx_q    <= flit;
                        rts_q   <= 1'b1;
                        ret_q   <= (rem_q != '0) ? StBody : StTail;
                        state_q <= StGap;
                    end
                end
                StBody: begin
                    if (take_word) begin
                        tx_q    <= flit;
                        rts_q   <= 1'b1;
                        rem_q   <= rem_q - 12'd1;
                        ret_q   <= (rem_q != 12'd1) ? StBody : StTail;
                        state_q <= StGap;
                    end
                end
                StTail: begin
                    if (take_word) begin
                        tx_q      <= flit;
                        rts_q     <= 1'b1;
                        pkt_cnt_q <= pkt_cnt_q + 16'd1;
                        seq_q     <= seq_q + 8'd1;
                        ret_q     <= StIdle;
                        state_q   <= StGap;
                    end
                end
                StGap: begin
                    state_q <= ret_q;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.TX        = tx_q;
    assign bus.RTS       = rts_q;
    assign bus.pay_ready = take_word;
    assign bus.pkt_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.pkt_cnt   = pkt_cnt_q;

endmodule
